// File: rtl/descrambler_64b66b_rx.sv
// rtl/descrambler_64b66b_rx.sv - 64b/66b receive block-lock FSM and self-synchronous descrambler
//
// Purpose:
//   Sits between the RX gearbox and the PCS decoder. Hunts for sync-header
//   alignment by requesting single-bit slips from the gearbox. Declares block
//   lock after SH_CNT_MAX consecutive good headers. Drops lock when INVLD_MAX
//   bad headers land inside one SH_CNT_MAX-beat window. Descrambles every
//   payload with x^58 + x^39 + 1.
//
// Ports:
//   clk       in   1   clock
//   nreset    in   1   synchronous active-low reset
//   valid_i   in   1   beat qualifier for sh_i / data_i
//   sh_i      in   2   sync header (LSB first on wire); 10 data, 01 control
//   data_i    in   64  scrambled payload, bit 0 first on wire
//   data_o    out  64  descrambled payload (holds between valid beats)
//   ctrl_o    out  1   emitted block carried a control header
//   valid_o   out  1   data_o / ctrl_o valid (only while locked)
//   sh_err_o  out  1   emitted block had an invalid header (00 or 11)
//   lock_o    out  1   block lock
//   slip_o    out  1   one-cycle bit-slip request to the gearbox

module descrambler_64b66b_rx #(
  parameter int SH_CNT_MAX = 64,
  parameter int INVLD_MAX  = 16,
  parameter int SLIP_WAIT  = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        valid_i,
  input  logic [1:0]  sh_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        ctrl_o,
  output logic        valid_o,
  output logic        sh_err_o,
  output logic        lock_o,
  output logic        slip_o
);

  localparam int SH_W = $clog2(SH_CNT_MAX + 1);
  localparam int IV_W = $clog2(INVLD_MAX + 1);
  localparam int WT_W = 4;

  localparam logic [SH_W-1:0] SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [IV_W-1:0] IV_LAST   = IV_W'(INVLD_MAX);
  localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_TEST = 2'd0,
    ST_SLIP = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic            lock_q;
  logic            slip_q;
  logic [SH_W-1:0] sh_cnt_q;
  logic [IV_W-1:0] invld_cnt_q;
  logic [WT_W-1:0] wait_cnt_q;
  logic [57:0]     s_q;

  logic [63:0]     data_q;
  logic            ctrl_q;
  logic            valid_q;
  logic            sh_err_q;

  logic            hdr_ok_d;
  logic [SH_W-1:0] sh_cnt_d;
  logic [IV_W-1:0] invld_cnt_d;
  logic [WT_W-1:0] wait_cnt_d;
  logic [121:0]    x_d;
  logic [63:0]     descr_d;

  assign hdr_ok_d    = sh_i[0] ^ sh_i[1];
  assign sh_cnt_d    = sh_cnt_q + 1'b1;
  assign invld_cnt_d = invld_cnt_q + 1'b1;
  assign wait_cnt_d  = wait_cnt_q + 1'b1;

  // s_q[57] is the most recently received bit, so x_d is the wire-order
  // history of 58 earlier scrambled bits followed by this beat's 64 bits.
  assign x_d = {data_i, s_q};

  always_comb begin
    descr_d = '0;
    for (int k = 0; k < 64; k++) begin
      descr_d[k] = x_d[k+58] ^ x_d[k+19] ^ x_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_TEST;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q  <= '0;
      s_q         <= '0;
      data_q      <= '0;
      ctrl_q      <= 1'b0;
      valid_q     <= 1'b0;
      sh_err_q    <= 1'b0;
    end else begin
      slip_q   <= 1'b0;
      valid_q  <= valid_i & lock_q;
      sh_err_q <= valid_i & (sh_i[0] == sh_i[1]);

      // The descrambler history tracks the received line bits regardless of
      // lock, which keeps it self-synchronising.
      if (valid_i) begin
        s_q    <= data_i[63:6];
        data_q <= descr_d;
        ctrl_q <= (sh_i == 2'b01);
      end

      case (state_q)
        ST_TEST: begin
          if (valid_i) begin
            if (!lock_q) begin
              if (!hdr_ok_d) begin
                state_q     <= ST_SLIP;
                slip_q      <= 1'b1;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
              end else if (sh_cnt_d == SH_LAST) begin
                lock_q      <= 1'b1;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
              end else begin
                sh_cnt_q    <= sh_cnt_d;
              end
            end else begin
              // Losing lock takes priority over a window end on the same beat.
              if (!hdr_ok_d && (invld_cnt_d == IV_LAST)) begin
                lock_q      <= 1'b0;
                state_q     <= ST_SLIP;
                slip_q      <= 1'b1;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
              end else if (sh_cnt_d == SH_LAST) begin
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
              end else begin
                sh_cnt_q    <= sh_cnt_d;
                if (!hdr_ok_d) begin
                  invld_cnt_q <= invld_cnt_d;
                end
              end
            end
          end
        end

        // The slip request lasts exactly one cycle. A valid beat arriving in
        // this cycle is already misaligned, so it is the first ignored beat.
        ST_SLIP: begin
          if ((SLIP_WAIT == 0) || (valid_i && (SLIP_WAIT == 1))) begin
            state_q    <= ST_TEST;
            wait_cnt_q <= '0;
          end else begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= valid_i ? WT_W'(1) : '0;
          end
        end

        ST_WAIT: begin
          if (valid_i) begin
            if (wait_cnt_d >= WAIT_LAST) begin
              state_q    <= ST_TEST;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_d;
            end
          end
        end

        default: begin
          state_q <= ST_TEST;
        end
      endcase
    end
  end

  assign data_o   = data_q;
  assign ctrl_o   = ctrl_q;
  assign valid_o  = valid_q;
  assign sh_err_o = sh_err_q;
  assign lock_o   = lock_q;
  assign slip_o   = slip_q;

endmodule

// File: tb/tb_descrambler_64b66b_rx.sv
// tb/tb_descrambler_64b66b_rx.sv - randomized self-checking bench for descrambler_64b66b_rx

module tb_descrambler_64b66b_rx;

  localparam int SH_CNT_MAX = 64;
  localparam int INVLD_MAX  = 16;
  localparam int SLIP_WAIT  = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  sh_i = 2'b10;
  logic [63:0] data_i = '0;
  logic [63:0] data_o;
  logic        ctrl_o;
  logic        valid_o;
  logic        sh_err_o;
  logic        lock_o;
  logic        slip_o;

  descrambler_64b66b_rx #(
    .SH_CNT_MAX(SH_CNT_MAX),
    .INVLD_MAX (INVLD_MAX),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .sh_i    (sh_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .ctrl_o  (ctrl_o),
    .valid_o (valid_o),
    .sh_err_o(sh_err_o),
    .lock_o  (lock_o),
    .slip_o  (slip_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: serial bit histories plus plain integer bookkeeping of
  // the lock rules (window count, bad-header count, beats left to ignore).
  bit          rx_hist[$];
  bit          tx_hist[$];
  bit          m_lock;
  int          m_cnt;
  int          m_inv;
  int          m_skip;
  bit          m_slip_cycle;
  logic [63:0] m_data;
  bit          m_ctrl;

  function automatic logic [63:0] model_descr(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i] = d[i] ^ rx_hist[19] ^ rx_hist[0];
      rx_hist.push_back(d[i]);
      void'(rx_hist.pop_front());
    end
    return r;
  endfunction

  function automatic logic [63:0] tx_scramble(input logic [63:0] p);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i] = p[i] ^ tx_hist[19] ^ tx_hist[0];
      tx_hist.push_back(r[i]);
      void'(tx_hist.pop_front());
    end
    return r;
  endfunction

  task automatic model_reset();
    rx_hist.delete();
    tx_hist.delete();
    for (int i = 0; i < 58; i++) begin
      rx_hist.push_back(1'b0);
      tx_hist.push_back(1'($urandom_range(0, 1)));
    end
    m_lock = 0; m_cnt = 0; m_inv = 0; m_skip = 0; m_slip_cycle = 0;
    m_data = '0; m_ctrl = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    nreset = 1'b0;
    valid_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_data_o", data_o, 64'd0);
    check_eq("rst_valid_o", valid_o, 64'd0);
    check_eq("rst_ctrl_o", ctrl_o, 64'd0);
    check_eq("rst_sh_err_o", sh_err_o, 64'd0);
    check_eq("rst_lock_o", lock_o, 64'd0);
    check_eq("rst_slip_o", slip_o, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic beat(input bit v, input logic [1:0] sh, input logic [63:0] d);
    bit e_valid;
    bit e_err;
    bit e_slip;
    bit ok;
    @(negedge clk);
    valid_i = v;
    sh_i    = sh;
    data_i  = d;
    e_valid = v & m_lock;
    e_err   = v & (sh[0] == sh[1]);
    e_slip  = 0;
    ok      = sh[0] ^ sh[1];
    if (v) begin
      m_data = model_descr(d);
      m_ctrl = (sh == 2'b01);
    end
    if (m_slip_cycle) begin
      m_slip_cycle = 0;
      m_skip = SLIP_WAIT;
      if (v && m_skip > 0) m_skip--;
    end else if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (!m_lock) begin
        if (!ok) begin
          e_slip = 1; m_cnt = 0; m_inv = 0;
        end else begin
          m_cnt++;
          if (m_cnt == SH_CNT_MAX) begin
            m_lock = 1; m_cnt = 0; m_inv = 0;
          end
        end
      end else begin
        m_cnt++;
        if (!ok) m_inv++;
        if (m_inv == INVLD_MAX) begin
          m_lock = 0; e_slip = 1; m_cnt = 0; m_inv = 0;
        end else if (m_cnt == SH_CNT_MAX) begin
          m_cnt = 0; m_inv = 0;
        end
      end
    end
    if (e_slip) m_slip_cycle = 1;
    @(posedge clk);
    #1;
    check_eq("valid_o", valid_o, e_valid);
    check_eq("data_o", data_o, m_data);
    check_eq("ctrl_o", ctrl_o, m_ctrl);
    check_eq("sh_err_o", sh_err_o, e_err);
    check_eq("lock_o", lock_o, m_lock);
    check_eq("slip_o", slip_o, e_slip);
  endtask

  // Scramble a payload as the TX side would, optionally flip one line bit,
  // and optionally compare the descrambled output with the original payload.
  task automatic tx_beat(input bit v, input logic [1:0] sh, input logic [63:0] pay,
                         input int flip, input bit lb_chk);
    logic [63:0] d;
    if (v) begin
      d = tx_scramble(pay);
      if (flip >= 0) d[flip] = ~d[flip];
    end else begin
      d = {$urandom, $urandom};
    end
    beat(v, sh, d);
    if (lb_chk && v) check_eq("loopback", data_o, pay);
  endtask

  function automatic logic [1:0] rand_good_sh();
    return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] rand_bad_sh();
    return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic acquire_lock();
    for (int i = 0; i < SLIP_WAIT + SH_CNT_MAX; i++) tx_beat(1, 2'b10, '0, -1, 0);
  endtask

  logic [63:0] pay0;
  logic [63:0] pay1;
  logic [63:0] err0;
  logic [63:0] err1;
  logic [127:0] exp_err;
  int          p;
  int          vcnt;

  initial begin
    do_reset(2);

    // Lock after exactly 64 good headers; valid_o follows one beat later.
    for (int i = 1; i <= SH_CNT_MAX; i++) begin
      tx_beat(1, 2'b10, '0, -1, i >= 2);
      if (i == SH_CNT_MAX - 1) check_eq("t1_lock_before", lock_o, 64'd0);
    end
    check_eq("t1_lock_at_64", lock_o, 64'd1);
    check_eq("t1_valid_not_yet", valid_o, 64'd0);
    tx_beat(1, 2'b10, '0, -1, 1);
    check_eq("t1_valid_beat65", valid_o, 64'd1);

    // Bad header while hunting: one slip pulse, two ignored beats, full window.
    do_reset(2);
    for (int i = 1; i <= 9; i++) tx_beat(1, 2'b10, '0, -1, 0);
    tx_beat(1, 2'b11, '0, -1, 0);
    check_eq("t2_slip_pulse", slip_o, 64'd1);
    tx_beat(1, 2'b11, '0, -1, 0);
    check_eq("t2_slip_once", slip_o, 64'd0);
    tx_beat(1, 2'b00, '0, -1, 0);
    check_eq("t2_ignored_no_slip", slip_o, 64'd0);
    for (int i = 1; i <= SH_CNT_MAX; i++) begin
      tx_beat(1, 2'b10, '0, -1, 0);
      if (i == SH_CNT_MAX - 1) check_eq("t2_lock_before", lock_o, 64'd0);
    end
    check_eq("t2_lock_after", lock_o, 64'd1);

    // 16 bad headers, the last on the window-end beat: drop wins.
    for (int i = 1; i <= SH_CNT_MAX; i++)
      tx_beat(1, (i % 4 == 0) ? rand_bad_sh() : 2'b10, '0, -1, 0);
    check_eq("t3_drop_lock", lock_o, 64'd0);
    check_eq("t3_drop_slip", slip_o, 64'd1);
    acquire_lock();
    check_eq("t3_relock", lock_o, 64'd1);
    // 15 bad headers per window for two windows: lock holds.
    for (int w = 0; w < 2; w++) begin
      for (int i = 1; i <= SH_CNT_MAX; i++)
        tx_beat(1, ((i % 4 == 0) && (i <= 60)) ? rand_bad_sh() : 2'b10, '0, -1, 0);
      check_eq("t3_hold_15", lock_o, 64'd1);
    end
    // 16 bad headers back-to-back: drop on the 16th.
    for (int i = 1; i <= INVLD_MAX; i++) tx_beat(1, 2'b11, '0, -1, 0);
    check_eq("t3_fast_drop", lock_o, 64'd0);

    // Loopback with random payload, then single-bit line errors.
    do_reset(2);
    for (int i = 1; i <= 80; i++)
      tx_beat(1, rand_good_sh(), {$urandom, $urandom}, -1, i >= 2);
    check_eq("t4_locked", lock_o, 64'd1);
    for (int r = 0; r < 3; r++) begin
      p = $urandom_range(0, 63);
      pay0 = {$urandom, $urandom};
      pay1 = {$urandom, $urandom};
      tx_beat(1, 2'b10, pay0, p, 0);
      err0 = data_o ^ pay0;
      tx_beat(1, 2'b10, pay1, -1, 0);
      err1 = data_o ^ pay1;
      exp_err = '0;
      exp_err[p] = 1'b1;
      exp_err[p + 39] = 1'b1;
      exp_err[p + 58] = 1'b1;
      check_eq("t4_err_blk0", err0, exp_err[63:0]);
      check_eq("t4_err_blk1", err1, exp_err[127:64]);
      for (int i = 0; i < 3; i++) tx_beat(1, 2'b10, {$urandom, $urandom}, -1, 1);
    end

    // Gapped valid: lock counts valid beats only, history holds on idles.
    do_reset(2);
    vcnt = 0;
    while (vcnt < SH_CNT_MAX + 20) begin
      if ($urandom_range(0, 1) != 0) begin
        vcnt++;
        tx_beat(1, 2'b10, {$urandom, $urandom}, -1, vcnt >= 2);
        if (vcnt == SH_CNT_MAX - 1) check_eq("t5_lock_before", lock_o, 64'd0);
        if (vcnt == SH_CNT_MAX) check_eq("t5_lock_at_64", lock_o, 64'd1);
      end else begin
        tx_beat(0, 2'b11, '0, -1, 0);
      end
    end

    // Reset while in WAIT after having been locked.
    do_reset(2);
    acquire_lock();
    for (int i = 1; i <= INVLD_MAX; i++) tx_beat(1, 2'b00, '0, -1, 0);
    check_eq("t6_dropped", lock_o, 64'd0);
    tx_beat(1, 2'b10, '0, -1, 0);
    do_reset(1);
    for (int i = 1; i <= SH_CNT_MAX; i++) tx_beat(1, 2'b10, '0, -1, 0);
    check_eq("t6_restart_lock", lock_o, 64'd1);

    // Random soak: gapped valid, occasional bad headers.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0)
        tx_beat(0, rand_bad_sh(), '0, -1, 0);
      else
        tx_beat(1, ($urandom_range(0, 29) == 0) ? rand_bad_sh() : rand_good_sh(),
                {$urandom, $urandom}, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
